// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that shares the register-file write-back port between NUM_REQ result sources.
// Optional macro WB_ARB_PERF_EN adds the conflict and hold performance counters.
module wb_port_arbiter #(
   parameter int NUM_REQ         = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int PREG_WIDTH      = 6,
   parameter int FREE_LIST_WIDTH = 5
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*PREG_WIDTH-1:0]      req_paddr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
   input  logic [NUM_REQ*FREE_LIST_WIDTH-1:0] req_alidx,
   input  logic                               flush,
   input  logic                               wb_hold,
   output logic                               wb_write_enable,
   output logic [PREG_WIDTH-1:0]              wb_physical_write_addr,
   output logic [DATA_WIDTH-1:0]              wb_physical_write_data,
   output logic [FREE_LIST_WIDTH-1:0]         wb_active_list_index,
   output logic                               busy
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]                        perf_conflict_cnt,
   output logic [31:0]                        perf_hold_cnt
`endif
);

   localparam int               PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

   logic [PREG_WIDTH-1:0]      w_paddr [NUM_REQ];
   logic [DATA_WIDTH-1:0]      w_data  [NUM_REQ];
   logic [FREE_LIST_WIDTH-1:0] w_alidx [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign w_paddr[gi] = req_paddr[gi*PREG_WIDTH +: PREG_WIDTH];
         assign w_data[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign w_alidx[gi] = req_alidx[gi*FREE_LIST_WIDTH +: FREE_LIST_WIDTH];
      end
   endgenerate

   logic [PTR_W-1:0]           r_rr_ptr;
   logic [PTR_W-1:0]           w_grant_idx;
   logic                       w_found;
   logic                       w_xfer;
   logic                       r_wb_we;
   logic [PREG_WIDTH-1:0]      r_wb_addr;
   logic [DATA_WIDTH-1:0]      r_wb_data;
   logic [FREE_LIST_WIDTH-1:0] r_wb_alidx;

   // Scan from the pointer upward with explicit wrap; first valid source wins.
   always_comb begin
      int j;
      j           = 0;
      w_found     = 1'b0;
      w_grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(r_rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!w_found && req_valid[j]) begin
            w_found     = 1'b1;
            w_grant_idx = PTR_W'(j);
         end
      end
   end

   assign w_xfer = w_found & ~flush & ~wb_hold;

   always_comb begin
      req_ready = '0;
      if (w_xfer) req_ready[w_grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_rr_ptr <= (w_grant_idx == LAST) ? '0 : w_grant_idx + 1'b1;
      end
   end

   // Writes to physical register 0 retire the source but never strobe the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_we    <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
         r_wb_alidx <= '0;
      end else if (w_xfer) begin
         r_wb_we    <= (w_paddr[w_grant_idx] != '0);
         r_wb_addr  <= w_paddr[w_grant_idx];
         r_wb_data  <= w_data[w_grant_idx];
         r_wb_alidx <= w_alidx[w_grant_idx];
      end else begin
         r_wb_we    <= 1'b0;
      end
   end

   assign wb_write_enable        = r_wb_we;
   assign wb_physical_write_addr = r_wb_addr;
   assign wb_physical_write_data = r_wb_data;
   assign wb_active_list_index   = r_wb_alidx;
   assign busy                   = (|req_valid) | r_wb_we;

`ifdef WB_ARB_PERF_EN
   logic        w_multi;
   logic [31:0] r_conflict_cnt;
   logic [31:0] r_hold_cnt;

   // Clearing the lowest set bit leaves something only when two or more sources are valid.
   assign w_multi = |(req_valid & (req_valid - 1'b1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= '0;
         r_hold_cnt     <= '0;
      end else begin
         if (!flush && !wb_hold && w_multi && (r_conflict_cnt != '1))
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
         if (wb_hold && (|req_valid) && (r_hold_cnt != '1))
            r_hold_cnt <= r_hold_cnt + 32'd1;
      end
   end

   assign perf_conflict_cnt = r_conflict_cnt;
   assign perf_hold_cnt     = r_hold_cnt;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single write-back port of the renaming register file between NUM_REQ functional-unit result sources, such as the ALU, the MUL/DIV unit and the LSU.
- Arbitration is round-robin and uses a per-requester valid/ready handshake.
- The winning result is registered into a one-cycle write-back stage, which drives the register file's wb_write_enable, wb_physical_write_addr, wb_physical_write_data and wb_active_list_index.
- A flush or a hold from the pipeline controller suppresses arbitration.

Parameters:
- NUM_REQ, 3, number of result sources; legal range 2..8.
- DATA_WIDTH, 32, width of the result data.
- PREG_WIDTH, 6, width of a physical register index.
- FREE_LIST_WIDTH, 5, width of an active-list index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  bit i: source i holds a result.
- req_ready  out  NUM_REQ  bit i: source i is granted this cycle (one-hot or zero).
- req_paddr  in  NUM_REQ*PREG_WIDTH  destination physical register; source i occupies slice [i*PREG_WIDTH +: PREG_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  result data, sliced the same way.
- req_alidx  in  NUM_REQ*FREE_LIST_WIDTH  active-list index of the instruction, sliced the same way.
- flush  in  1  discard pending and in-flight write-back.
- wb_hold  in  1  suspend granting.
- wb_write_enable  out  1  write strobe to the register file.
- wb_physical_write_addr  out  PREG_WIDTH  write address.
- wb_physical_write_data  out  DATA_WIDTH  write data.
- wb_active_list_index  out  FREE_LIST_WIDTH  active-list entry to mark done.
- busy  out  1  any req_valid is high, or wb_write_enable is high.

Behaviour:
- Reset values:
  - wb_write_enable=0, wb_physical_write_addr=0, wb_physical_write_data=0, wb_active_list_index=0.
  - Round-robin pointer rr_ptr=0.
- Grant (combinational):
  - If flush or wb_hold is high, req_ready=0.
  - Otherwise req_ready is one-hot on the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap-around modulo NUM_REQ.
  - If no source is valid, req_ready=0.
- Transfer: occurs when req_valid[i] and req_ready[i] are both high. A source must keep valid and its payload stable until that transfer.
- Pointer update:
  - On a transfer from source i, rr_ptr <= (i+1) mod NUM_REQ at the clock edge.
  - Wrap at NUM_REQ uses explicit compare; the pointer never relies on power-of-two overflow.
  - With no transfer, rr_ptr is unchanged.
  - flush does not modify rr_ptr.
- Write-back stage, registered with latency 1:
  - A transfer in cycle N presents the payload on the wb_* outputs in cycle N+1.
  - wb_write_enable is high in cycle N+1 only, unless another transfer occurs in cycle N+1.
  - The port sustains back-to-back writes at 1 per cycle.
- Zero register: a transfer with paddr==0 is consumed (ready asserted, source retires) but wb_write_enable stays 0. The addr/data/index registers still update.
- No transfer: wb_write_enable <= 0. The addr/data/index registers hold their values.
- flush in cycle N:
  - No grant is issued in cycle N.
  - wb_write_enable <= 0 at the edge, killing any write that would otherwise be issued in cycle N+1.
  - A write already on the wb_* outputs during cycle N still completes, because the register file samples it at that same edge.
- wb_hold: no grant, and wb_write_enable <= 0 at the edge. Sources keep their requests pending.
- flush and wb_hold together: treated as flush.
- Fairness: every continuously valid source is granted within NUM_REQ cycles in which flush and wb_hold are both low.
- Reset mid-operation: all state returns to its reset value asynchronously, and pending requests are dropped.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined:
  - Adds output perf_conflict_cnt, 32 bits. It increments by 1 in every cycle where flush=0, wb_hold=0 and at least two bits of req_valid are high. It saturates at 0xFFFFFFFF.
  - Adds output perf_hold_cnt, 32 bits. It increments in every cycle where wb_hold=1 and req_valid is nonzero. It saturates the same way.
  - Both counters reset to 0 and are not cleared by flush.
- When undefined: neither the ports nor the logic exist, and the remaining behaviour is identical.

Test Plan:
- Single source: after reset, req_valid=3'b010, paddr1=6'd33, data1=32'hDEADBEEF, alidx1=5'd4.
  - Cycle 0: req_ready=3'b010.
  - Cycle 1: wb_write_enable=1, addr=33, data=DEADBEEF, index=4.
  - Next cycle: rr_ptr=2.
- Contention: req_valid=3'b111 held for 6 cycles with rr_ptr=0 and distinct payloads.
  - Grant order: 0,1,2,0,1,2.
  - wb_write_enable is high on 6 consecutive cycles with matching addresses.
- Zero register: source 0 valid with paddr=0, data=32'h1234.
  - Cycle 0: req_ready=3'b001.
  - Cycle 1: wb_write_enable=0 and wb_physical_write_data=32'h1234.
- Flush: grant to source 2 (paddr=40) in cycle N, then flush=1 in cycle N+1 while source 0 is valid.
  - Cycle N+1: write of preg 40 is visible, req_ready=0.
  - Cycle N+2: wb_write_enable=0.
  - rr_ptr stays 0.
- Hold then release: wb_hold=1 for 3 cycles with req_valid=3'b101.
  - During hold: req_ready=0 and wb_write_enable=0.
  - First cycle after release: source 0 is granted, then source 2.
  - With WB_ARB_PERF_EN: perf_hold_cnt=3 and perf_conflict_cnt=1 after the source 0 grant.
- Asynchronous reset: rst_n deasserted mid-burst while wb_write_enable=1.
  - All wb_* outputs go to 0 immediately, without waiting for a clock edge.
  - rr_ptr=0 after release.
